// File: rtl/instr_queue_param.sv
// Parametrised in-order instruction queue feeding Tomasulo ALU/branch reservation stations.
// Optional same-cycle bypass of an enqueue into an empty queue: define IQ_BYPASS_EN.
module instr_queue_param #(
    parameter int DEPTH  = 8,
    parameter int NUM_RS = 4,
    parameter int XLEN   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enq_valid,
    input  logic [XLEN-1:0]         enq_instr,
    input  logic [XLEN-1:0]         enq_pc,
    output logic                    enq_ready,
    input  logic                    flush,
    input  logic                    rob_full,
    input  logic [NUM_RS-1:0]       rs_empty,
    input  logic                    resbr_empty,
    output logic [NUM_RS-1:0]       rs_load,
    output logic                    resbr_load,
    output logic                    rob_load,
    output logic [XLEN-1:0]         deq_instr,
    output logic [XLEN-1:0]         deq_pc,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [XLEN-1:0]   instr_mem [DEPTH];
    logic [XLEN-1:0]   pc_mem    [DEPTH];
    logic [AW:0]       head;
    logic [AW:0]       tail;
    logic              empty;
    logic              full;
    logic              bypass;
    logic              head_valid;
    logic              enq_fire;
    logic              is_branch;
    logic              alu_free;
    logic              issue;
    logic [NUM_RS-1:0] rs_pick;
    logic [6:0]        opcode;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (head == tail);
    assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
    assign count = tail - head;

    assign enq_ready = !rst && !full;
    assign enq_fire  = enq_valid && enq_ready && !flush;

`ifdef IQ_BYPASS_EN
    assign bypass = empty && enq_valid && !flush && !rst;
`else
    assign bypass = 1'b0;
`endif

    assign head_valid = !empty || bypass;
    assign deq_instr  = bypass ? enq_instr : instr_mem[head[AW-1:0]];
    assign deq_pc     = bypass ? enq_pc    : pc_mem[head[AW-1:0]];
    assign opcode     = deq_instr[6:0];
    assign is_branch  = (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);

    // Lowest-index free ALU station wins.
    always_comb begin
        rs_pick  = '0;
        alu_free = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (rs_empty[i] && !alu_free) begin
                rs_pick[i] = 1'b1;
                alu_free   = 1'b1;
            end
        end
    end

    // A blocked head stalls everything behind it; no out-of-order issue.
    assign issue = !rst && head_valid && !rob_full && !flush
                   && (is_branch ? resbr_empty : alu_free);

    assign rs_load    = (issue && !is_branch) ? rs_pick : '0;
    assign resbr_load = issue && is_branch;
    assign rob_load   = issue;

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            instr_mem[tail[AW-1:0]] <= enq_instr;
            pc_mem[tail[AW-1:0]]    <= enq_pc;
        end
    end

    // A bypassed issue advances both pointers, so the written slot is consumed at once.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PTR_ONE;
            end
            if (issue) begin
                head <= head + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_instr_queue_param.sv
// Self-checking bench for instr_queue_param: directed scenarios plus a randomized run
// against a queue-based reference model. Honours IQ_BYPASS_EN when defined.
module tb_instr_queue_param;

    localparam int DEPTH  = 8;
    localparam int NUM_RS = 4;
    localparam int XLEN   = 32;

    logic              clk;
    logic              rst;
    logic              enq_valid;
    logic [XLEN-1:0]   enq_instr;
    logic [XLEN-1:0]   enq_pc;
    logic              enq_ready;
    logic              flush;
    logic              rob_full;
    logic [NUM_RS-1:0] rs_empty;
    logic              resbr_empty;
    logic [NUM_RS-1:0] rs_load;
    logic              resbr_load;
    logic              rob_load;
    logic [XLEN-1:0]   deq_instr;
    logic [XLEN-1:0]   deq_pc;
    logic [3:0]        count;

    int n_tests = 0;
    int n_fail  = 0;

    instr_queue_param #(.DEPTH(DEPTH), .NUM_RS(NUM_RS), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_instr(enq_instr),
        .enq_pc(enq_pc), .enq_ready(enq_ready), .flush(flush), .rob_full(rob_full),
        .rs_empty(rs_empty), .resbr_empty(resbr_empty), .rs_load(rs_load),
        .resbr_load(resbr_load), .rob_load(rob_load), .deq_instr(deq_instr),
        .deq_pc(deq_pc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_valid   = 1'b0;
        enq_instr   = '0;
        enq_pc      = '0;
        flush       = 1'b0;
        rob_full    = 1'b0;
        rs_empty    = '0;
        resbr_empty = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] alu_instr();
        logic [31:0] v;
        v = $urandom;
        v[6:0] = 7'b0110011;
        return v;
    endfunction

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        enq_valid = 1'b1; enq_instr = 32'h000170b3; rs_empty = 4'b1111; resbr_empty = 1'b1;
        #2;
        n_tests++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL rst_enq_ready: got %b expected 0", enq_ready); end
        n_tests++; if (rob_load !== 1'b0) begin n_fail++; $display("FAIL rst_rob_load: got %b expected 0", rob_load); end
        n_tests++; if (rs_load !== 4'b0000) begin n_fail++; $display("FAIL rst_rs_load: got %b expected 0000", rs_load); end
        n_tests++; if (resbr_load !== 1'b0) begin n_fail++; $display("FAIL rst_resbr_load: got %b expected 0", resbr_load); end
        tick();
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
        rst = 1'b0;
        idle();
        #2;
        n_tests++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", enq_ready); end
        tick();
    endtask

    task automatic test_alu_issue();
        do_reset();
        rs_empty = 4'b1111;
        enq_valid = 1'b1; enq_instr = 32'h000170b3; enq_pc = 32'h0000_0100;
        #2;
`ifdef IQ_BYPASS_EN
        n_tests++; if (rs_load !== 4'b0001) begin n_fail++; $display("FAIL alu_bypass_rs_load: got %b expected 0001", rs_load); end
        tick();
        enq_valid = 1'b0;
        #2;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL alu_bypass_count: got %0d expected 0", count); end
`else
        n_tests++; if (rob_load !== 1'b0) begin n_fail++; $display("FAIL alu_early_rob_load: got %b expected 0", rob_load); end
        tick();
        enq_valid = 1'b0;
        #2;
        n_tests++; if (rs_load !== 4'b0001) begin n_fail++; $display("FAIL alu_rs_load: got %b expected 0001", rs_load); end
        n_tests++; if (rob_load !== 1'b1) begin n_fail++; $display("FAIL alu_rob_load: got %b expected 1", rob_load); end
        n_tests++; if (deq_instr !== 32'h000170b3) begin n_fail++; $display("FAIL alu_deq_instr: got %h expected 000170b3", deq_instr); end
        n_tests++; if (deq_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL alu_deq_pc: got %h expected 00000100", deq_pc); end
        n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL alu_count1: got %0d expected 1", count); end
        tick();
`endif
        #2;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL alu_count0: got %0d expected 0", count); end
        n_tests++; if (rob_load !== 1'b0) begin n_fail++; $display("FAIL alu_idle_rob_load: got %b expected 0", rob_load); end
    endtask

    task automatic test_fill_and_wrap();
        logic [63:0] exp_q[$];
        logic        exp_ready;
        int          guard;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            enq_valid = 1'b1; enq_instr = alu_instr(); enq_pc = 32'h1000 + i * 4;
            exp_q.push_back({enq_pc, enq_instr});
            tick();
        end
        enq_valid = 1'b0;
        #2;
        n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d expected 8", count); end
        n_tests++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b expected 0", enq_ready); end
        enq_valid = 1'b1; enq_instr = 32'hdead_0033; enq_pc = 32'hffff_0000;
        tick();
        n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL ninth_enq_count: got %0d expected 8", count); end
        rs_empty = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            enq_valid = 1'b1; enq_instr = alu_instr(); enq_pc = 32'h2000 + i * 4;
            exp_ready = (exp_q.size() < DEPTH);
            #2;
            n_tests++; if (rs_load !== 4'b0100) begin n_fail++; $display("FAIL wrap_rs_load[%0d]: got %b expected 0100", i, rs_load); end
            n_tests++; if (deq_instr !== exp_q[0][31:0]) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, deq_instr, exp_q[0][31:0]); end
            n_tests++; if (enq_ready !== exp_ready) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b expected %b", i, enq_ready, exp_ready); end
            tick();
            if (exp_ready) exp_q.push_back({enq_pc, enq_instr});
            void'(exp_q.pop_front());
        end
        enq_valid = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            #2;
            n_tests++; if (deq_pc !== exp_q[0][63:32]) begin n_fail++; $display("FAIL drain_pc: got %h expected %h", deq_pc, exp_q[0][63:32]); end
            tick();
            void'(exp_q.pop_front());
            guard++;
        end
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", count); end
    endtask

    task automatic test_hol_block();
        do_reset();
        rs_empty = 4'b1111; resbr_empty = 1'b0;
        enq_valid = 1'b1; enq_instr = 32'h00208463; enq_pc = 32'h40;
        tick();
        enq_instr = 32'h000170b3; enq_pc = 32'h44;
        tick();
        enq_valid = 1'b0;
        #2;
        n_tests++; if (rob_load !== 1'b0) begin n_fail++; $display("FAIL hol_rob_load: got %b expected 0", rob_load); end
        n_tests++; if (rs_load !== 4'b0000) begin n_fail++; $display("FAIL hol_rs_load: got %b expected 0000", rs_load); end
        n_tests++; if (deq_instr !== 32'h00208463) begin n_fail++; $display("FAIL hol_head: got %h expected 00208463", deq_instr); end
        tick();
        n_tests++; if (count !== 4'd2) begin n_fail++; $display("FAIL hol_count: got %0d expected 2", count); end
        resbr_empty = 1'b1;
        #2;
        n_tests++; if (resbr_load !== 1'b1) begin n_fail++; $display("FAIL hol_resbr_load: got %b expected 1", resbr_load); end
        n_tests++; if (rob_load !== 1'b1) begin n_fail++; $display("FAIL hol_release_rob: got %b expected 1", rob_load); end
        n_tests++; if (rs_load !== 4'b0000) begin n_fail++; $display("FAIL hol_release_rs: got %b expected 0000", rs_load); end
        tick();
        resbr_empty = 1'b0; rs_empty = 4'b1010;
        #2;
        n_tests++; if (rs_load !== 4'b0010) begin n_fail++; $display("FAIL hol_next_rs: got %b expected 0010", rs_load); end
        tick();
    endtask

    task automatic test_rob_full_flush();
        do_reset();
        rs_empty = 4'b1111; resbr_empty = 1'b1; rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1; enq_instr = alu_instr(); enq_pc = 32'h80 + i * 4;
            tick();
        end
        enq_valid = 1'b0;
        #2;
        n_tests++; if (rob_load !== 1'b0) begin n_fail++; $display("FAIL robfull_rob_load: got %b expected 0", rob_load); end
        n_tests++; if (count !== 4'd3) begin n_fail++; $display("FAIL robfull_count: got %0d expected 3", count); end
        rob_full = 1'b0; flush = 1'b1;
        enq_valid = 1'b1; enq_instr = 32'h11111033; enq_pc = 32'h900;
        #2;
        n_tests++; if (rob_load !== 1'b0 || rs_load !== 4'b0000) begin n_fail++; $display("FAIL flush_strobes: got rob %b rs %b expected 0 0000", rob_load, rs_load); end
        tick();
        flush = 1'b0; enq_valid = 1'b0; rs_empty = 4'b0000;
        #2;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
        enq_valid = 1'b1; enq_instr = 32'h22222033; enq_pc = 32'ha00;
        tick();
        enq_valid = 1'b0;
        #2;
        n_tests++; if (count !== 4'd1 || deq_instr !== 32'h22222033) begin n_fail++; $display("FAIL flush_refill: got count %0d head %h expected 1 22222033", count, deq_instr); end
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            enq_valid = 1'b1; enq_instr = alu_instr(); enq_pc = 32'h300 + i * 4;
            tick();
        end
        rs_empty = 4'b0010;
        enq_valid = 1'b1; enq_instr = 32'h33333033;
        #2;
        n_tests++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_issue_ready: got %b expected 0", enq_ready); end
        n_tests++; if (rs_load !== 4'b0010) begin n_fail++; $display("FAIL full_issue_rs: got %b expected 0010", rs_load); end
        tick();
        n_tests++; if (count !== 4'd7) begin n_fail++; $display("FAIL full_issue_count: got %0d expected 7", count); end
        enq_instr = 32'h44444033;
        #2;
        n_tests++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready: got %b expected 1", enq_ready); end
        n_tests++; if (rob_load !== 1'b1) begin n_fail++; $display("FAIL simul_rob: got %b expected 1", rob_load); end
        tick();
        enq_valid = 1'b0;
        n_tests++; if (count !== 4'd7) begin n_fail++; $display("FAIL simul_count: got %0d expected 7", count); end
    endtask

    task automatic test_bypass();
        do_reset();
        rs_empty = 4'b0001;
        enq_valid = 1'b1; enq_instr = 32'h00b08093; enq_pc = 32'h500;
        #2;
`ifdef IQ_BYPASS_EN
        n_tests++; if (rs_load !== 4'b0001) begin n_fail++; $display("FAIL bypass_rs_load: got %b expected 0001", rs_load); end
        n_tests++; if (deq_instr !== 32'h00b08093) begin n_fail++; $display("FAIL bypass_deq: got %h expected 00b08093", deq_instr); end
        tick();
        enq_valid = 1'b0;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL bypass_count: got %0d expected 0", count); end
`else
        n_tests++; if (rs_load !== 4'b0000) begin n_fail++; $display("FAIL nobypass_rs_load0: got %b expected 0000", rs_load); end
        tick();
        enq_valid = 1'b0;
        #2;
        n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL nobypass_count1: got %0d expected 1", count); end
        n_tests++; if (rs_load !== 4'b0001) begin n_fail++; $display("FAIL nobypass_rs_load1: got %b expected 0001", rs_load); end
        tick();
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL nobypass_count0: got %0d expected 0", count); end
`endif
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic [6:0]  ops [8];
        logic        hv, br, exp_ready, exp_rob, exp_br, found;
        logic [31:0] hi, hp;
        logic [3:0]  exp_rs;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        do_reset();
        for (int c = 0; c < 800; c++) begin
            enq_valid   = ($urandom_range(0, 99) < 60);
            enq_instr   = $urandom;
            enq_instr[6:0] = ops[$urandom_range(0, 7)];
            enq_pc      = $urandom;
            flush       = ($urandom_range(0, 99) < 3);
            rob_full    = ($urandom_range(0, 99) < (((c / 100) % 2 == 1) ? 70 : 15));
            rs_empty    = 4'($urandom);
            resbr_empty = 1'($urandom);

            hv = (q.size() > 0);
            hi = hv ? q[0][31:0] : '0;
            hp = hv ? q[0][63:32] : '0;
`ifdef IQ_BYPASS_EN
            if (!hv && enq_valid && !flush) begin hv = 1'b1; hi = enq_instr; hp = enq_pc; end
`endif
            br = (hi[6:0] == 7'b1100011) || (hi[6:0] == 7'b1101111) || (hi[6:0] == 7'b1100111);
            exp_ready = (q.size() < DEPTH);
            exp_rs = '0; exp_br = 1'b0; found = 1'b0;
            if (hv && !rob_full && !flush) begin
                if (br) exp_br = resbr_empty;
                else begin
                    for (int i = 0; i < NUM_RS; i++)
                        if (rs_empty[i] && !found) begin exp_rs[i] = 1'b1; found = 1'b1; end
                end
            end
            exp_rob = exp_br || (exp_rs != 4'b0000);
            #2;
            n_tests++; if (enq_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, enq_ready, exp_ready); end
            n_tests++; if (rs_load !== exp_rs) begin n_fail++; $display("FAIL rnd_rs_load c%0d: got %b expected %b", c, rs_load, exp_rs); end
            n_tests++; if (resbr_load !== exp_br) begin n_fail++; $display("FAIL rnd_resbr c%0d: got %b expected %b", c, resbr_load, exp_br); end
            n_tests++; if (rob_load !== exp_rob) begin n_fail++; $display("FAIL rnd_rob c%0d: got %b expected %b", c, rob_load, exp_rob); end
            n_tests++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, count, q.size()); end
            if (hv) begin
                n_tests++; if (deq_instr !== hi || deq_pc !== hp) begin n_fail++; $display("FAIL rnd_head c%0d: got %h/%h expected %h/%h", c, deq_instr, deq_pc, hi, hp); end
            end
            tick();
            if (flush) q.delete();
            else begin
                if (enq_valid && exp_ready) q.push_back({enq_pc, enq_instr});
                if (exp_rob) void'(q.pop_front());
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_alu_issue();
        test_fill_and_wrap();
        test_hol_block();
        test_rob_full_flush();
        test_full_simul();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
